secded_stream_decoder: RTL and testbench

SECDED_STREAM_DECODER -- requirements
Module: secded_stream_decoder

---
 rtl/secded_stream_decoder.sv | 136 +++++++++++++
 tb/tb_secded_stream_decoder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_stream_decoder.sv
// secded_stream_decoder: two-stage pipelined extended-Hamming (SECDED) decoder
// with valid/ready streaming and saturating CE/UE counters.
module secded_stream_decoder #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16,
   // smallest r with 2**r >= DATA_W+r+1; closed form holds for DATA_W >= 8
   localparam int R     = $clog2(DATA_W + $clog2(DATA_W) + 1),
   localparam int P     = R + 1,
   localparam int CW_W  = DATA_W + P
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_cw,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ce,
   output logic              out_ue,
   output logic [P-1:0]      out_syndrome,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  ce_count,
   output logic [CNT_W-1:0]  ue_count
);

   // Hamming position of each data bit: integers >= 3 skipping powers of two
   function automatic logic [DATA_W*R-1:0] pos_table();
      logic [DATA_W*R-1:0] t;
      int n;
      t = '0;
      n = 0;
      for (int p = 3; p < 256; p++) begin
         if (((p & (p - 1)) != 0) && (n < DATA_W)) begin
            t[n*R +: R] = R'(p);
            n++;
         end
      end
      return t;
   endfunction

   localparam logic [DATA_W*R-1:0] POS = pos_table();

   logic              adv;
   logic              deliver;
   logic              v1;
   logic              v2;
   logic [DATA_W-1:0] s1_data;
   logic [P-1:0]      s1_syn;
   logic [R-1:0]      chk;
   logic [P-1:0]      syn_in;
   logic [R-1:0]      syn;
   logic              om;
   logic              hit;
   logic              pow2;
   logic [DATA_W-1:0] fix_data;
   logic              fix_ce;
   logic              fix_ue;

   assign adv       = !v2 || out_ready;
   assign in_ready  = adv;
   assign out_valid = v2;
   assign deliver   = v2 && out_ready;

   // Recompute check bits from received data and form the syndrome
   always_comb begin
      chk = '0;
      for (int i = 0; i < DATA_W; i++) begin
         for (int j = 0; j < R; j++) begin
            if (POS[i*R + j]) begin
               chk[j] = chk[j] ^ in_cw[i];
            end
         end
      end
      syn_in = {^in_cw, chk ^ in_cw[DATA_W +: R]};
   end

   // Classify the registered syndrome and correct a single data-bit error
   always_comb begin
      syn      = s1_syn[R-1:0];
      om       = s1_syn[R];
      fix_data = s1_data;
      hit      = 1'b0;
      for (int k = 0; k < DATA_W; k++) begin
         if (syn == POS[k*R +: R]) begin
            hit = 1'b1;
            if (om) begin
               fix_data[k] = ~s1_data[k];
            end
         end
      end
      // zero or a single check-bit position
      pow2   = (syn & (syn - R'(1))) == '0;
      fix_ce = om && (pow2 || hit);
      fix_ue = om ? !(pow2 || hit) : (syn != '0);
   end

   // Pipeline registers; everything holds while the output is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         v1           <= 1'b0;
         v2           <= 1'b0;
         s1_data      <= '0;
         s1_syn       <= '0;
         out_data     <= '0;
         out_ce       <= 1'b0;
         out_ue       <= 1'b0;
         out_syndrome <= '0;
      end else if (adv) begin
         v1           <= in_valid;
         s1_data      <= in_cw[DATA_W-1:0];
         s1_syn       <= syn_in;
         v2           <= v1;
         out_data     <= fix_data;
         out_ce       <= fix_ce;
         out_ue       <= fix_ue;
         out_syndrome <= s1_syn;
      end
   end

   // Saturating error counters; clear wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         ce_count <= '0;
         ue_count <= '0;
      end else if (deliver) begin
         if (out_ce && (ce_count != '1)) begin
            ce_count <= ce_count + CNT_W'(1);
         end
         if (out_ue && (ue_count != '1)) begin
            ue_count <= ue_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// tb_secded_stream_decoder: randomized scoreboard bench for the SECDED decoder
// with a position-index reference model.
module tb_secded_stream_decoder;

   localparam int DW = 64;
   localparam int CW = 72;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_cw = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic          out_ce;
   logic          out_ue;
   logic [7:0]    out_syndrome;
   logic          cnt_clr = 1'b0;
   logic [1:0]    ce_count;
   logic [1:0]    ue_count;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rdy_mode = 0;
   bit clr_rand = 1'b0;

   typedef struct {
      logic [DW-1:0] d;
      logic          ce;
      logic          ue;
      logic [7:0]    syn;
      int            acc;
   } exp_t;

   exp_t q[$];

   secded_stream_decoder #(.DATA_W(64), .CNT_W(2)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_cw(in_cw),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_ce(out_ce),
      .out_ue(out_ue),
      .out_syndrome(out_syndrome),
      .cnt_clr(cnt_clr),
      .ce_count(ce_count),
      .ue_count(ue_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // position of data bit i: (i+1)-th integer >= 3 that is not a power of two
   function automatic int dpos(input int i);
      int n;
      int p;
      n = 0;
      p = 2;
      while (n <= i) begin
         p++;
         if ((p & (p - 1)) != 0) n++;
      end
      return p;
   endfunction

   // check bits are chosen so the XOR of all set positions is zero
   function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
      logic [CW-1:0] cw;
      int s;
      s = 0;
      for (int i = 0; i < DW; i++) if (d[i]) s = s ^ dpos(i);
      cw = '0;
      cw[DW-1:0] = d;
      for (int j = 0; j < 7; j++) cw[DW+j] = ((s >> j) & 1) != 0;
      cw[CW-1] = ^cw[CW-2:0];
      return cw;
   endfunction

   function automatic exp_t model(input logic [CW-1:0] cw);
      exp_t e;
      int s;
      logic om;
      bit found;
      s = 0;
      om = ^cw;
      for (int i = 0; i < DW; i++) if (cw[i]) s = s ^ dpos(i);
      for (int j = 0; j < 7; j++) if (cw[DW+j]) s = s ^ (1 << j);
      e.d = cw[DW-1:0];
      e.syn = {om, 7'(s)};
      e.ce = 1'b0;
      e.ue = 1'b0;
      e.acc = 0;
      if (om) begin
         if (s == 0 || (s & (s - 1)) == 0) begin
            e.ce = 1'b1;
         end else begin
            found = 1'b0;
            for (int i = 0; i < DW; i++) begin
               if (dpos(i) == s) begin
                  e.d[i] = ~e.d[i];
                  found = 1'b1;
               end
            end
            e.ce = found;
            e.ue = !found;
         end
      end else if (s != 0) begin
         e.ue = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [CW-1:0] rand_cw();
      logic [CW-1:0] cw;
      int b1;
      int b2;
      cw = encode({$urandom, $urandom});
      b1 = $urandom_range(0, CW - 1);
      b2 = (b1 + 1 + $urandom_range(0, CW - 2)) % CW;
      case ($urandom_range(0, 5))
         2, 3: cw[b1] = ~cw[b1];
         4: begin
            cw[b1] = ~cw[b1];
            cw[b2] = ~cw[b2];
         end
         5: cw = {8'($urandom), $urandom, $urandom};
         default: ;
      endcase
      return cw;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic send(input logic [CW-1:0] cw);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_cw = cw;
      cnt_clr = clr_rand && ($urandom_range(0, 7) == 0);
      #4;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         #4;
         n++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: in_ready got 0 want 1");
      end else begin
         e = model(cw);
         e.acc = cyc;
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cnt_clr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // downstream ready pattern
   initial begin
      forever begin
         @(negedge clk);
         case (rdy_mode)
            1: out_ready = ($urandom_range(0, 3) != 0);
            2: out_ready = 1'b0;
            default: out_ready = 1'b1;
         endcase
      end
   end

   // monitor: sample just before each rising edge
   initial begin
      int mce;
      int mue;
      int last_stall;
      bit prev_rst;
      bit dlv;
      exp_t e;
      mce = 0;
      mue = 0;
      last_stall = -1;
      prev_rst = 1'b0;
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            q.delete();
            mce = 0;
            mue = 0;
            prev_rst = 1'b1;
         end else begin
            if (prev_rst) begin
               chk("rst_out_valid", 64'(out_valid), 64'd0);
               chk("rst_out_data", out_data, 64'd0);
               chk("rst_out_syndrome", 64'(out_syndrome), 64'd0);
               chk("rst_out_ce", 64'(out_ce), 64'd0);
               chk("rst_out_ue", 64'(out_ue), 64'd0);
               chk("rst_in_ready", 64'(in_ready), 64'd1);
            end
            prev_rst = 1'b0;
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            chk("ce_count", 64'(ce_count), 64'(mce));
            chk("ue_count", 64'(ue_count), 64'(mue));
            if (!out_ready) last_stall = cyc;
            dlv = 1'b0;
            if (out_valid) begin
               if (q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_word: got %h want none", out_data);
               end else begin
                  e = q[0];
                  chk("out_data", out_data, e.d);
                  chk("out_ce", 64'(out_ce), 64'(e.ce));
                  chk("out_ue", 64'(out_ue), 64'(e.ue));
                  chk("out_syndrome", 64'(out_syndrome), 64'(e.syn));
                  if (out_ready) begin
                     void'(q.pop_front());
                     dlv = 1'b1;
                     if (e.acc >= last_stall)
                        chk("latency", 64'(cyc - e.acc), 64'd2);
                  end
               end
            end
            if (cnt_clr) begin
               mce = 0;
               mue = 0;
            end else if (dlv) begin
               if (e.ce && mce < 3) mce++;
               if (e.ue && mue < 3) mue++;
            end
         end
      end
   end

   // stimulus
   initial begin
      logic [CW-1:0] cw;
      int n;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle(2);

      // directed words
      send(encode(64'h0123_4567_89AB_CDEF));
      send(encode(64'h0) ^ 72'h1);
      send(encode(64'h0) ^ 72'h3);
      cw = '0;
      cw[71] = 1'b1;
      send(encode(64'h0) ^ cw);
      idle(6);

      // four-word stream with a 5-cycle downstream stall
      send(rand_cw());
      rdy_mode = 2;
      fork
         begin
            send(rand_cw());
            send(rand_cw());
            send(rand_cw());
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            rdy_mode = 0;
         end
      join
      idle(6);

      // counter saturation, then clear on the cycle of a CE delivery
      for (int i = 0; i < 5; i++) begin
         cw = encode({$urandom, $urandom});
         n = $urandom_range(0, DW - 1);
         cw[n] = ~cw[n];
         send(cw);
      end
      idle(4);
      cw = encode({$urandom, $urandom});
      cw[5] = ~cw[5];
      send(cw);
      @(negedge clk);
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      idle(4);

      // reset with two words in flight
      rdy_mode = 2;
      send(encode(64'h0) ^ 72'h1);
      send(encode(64'h0) ^ 72'h3);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rdy_mode = 0;
      idle(10);

      // randomized traffic
      rdy_mode = 1;
      clr_rand = 1'b1;
      repeat (400) send(rand_cw());
      clr_rand = 1'b0;
      rdy_mode = 0;

      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_left", 64'(q.size()), 64'd0);
      idle(3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
